pll_lock_sequencer: RTL

- Sits directly downstream of the PLL clock-synthesis wrapper and runs on the same free-running reference clock that feeds the PLL.
- Drives the PLL reset, qualifies the PLL locked output (synchronise, then stability window), and releases the system reset only once lock is stable.
- On loss of lock it re-asserts system reset and retries the PLL. Repeated lock failures escalate to a sticky fault.

---
 rtl/pll_lock_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL lock sequencer: drives the PLL reset, qualifies the asynchronous locked
// signal and releases the downstream system reset only after lock is stable.
module pll_lock_sequencer #(
   parameter int  RST_CYCLES    = 16,
   parameter int  LOCK_TIMEOUT  = 4096,
   parameter int  STABLE_CYCLES = 256,
   parameter int  MAX_RETRIES   = 3,
   parameter int  LOSS_W        = 8,
   localparam int RW            = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
   input  logic              clk_in1,
   input  logic              reset_n,
   input  logic              locked,
   input  logic              clear_fault,
   output logic              pll_reset,
   output logic              sys_reset_n,
   output logic              ready,
   output logic              fault,
   output logic [2:0]        state,
   output logic [RW-1:0]     retry_cnt,
   output logic [LOSS_W-1:0] loss_cnt
);

   localparam int TMAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int TMAX   = (TMAX_A > STABLE_CYCLES) ? TMAX_A : STABLE_CYCLES;
   localparam int TW     = (TMAX > 1) ? $clog2(TMAX) : 1;

   localparam logic [TW-1:0] RST_LAST     = TW'(RST_CYCLES - 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
   localparam logic [TW-1:0] STABLE_LAST  = TW'(STABLE_CYCLES - 1);
   localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);

   typedef enum logic [2:0] {
      RESET_PLL = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RUN       = 3'd3,
      FAULT     = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [TW-1:0]     timer_q, timer_d;
   logic [RW-1:0]     retry_q, retry_d;
   logic [LOSS_W-1:0] loss_q, loss_d;
   logic [1:0]        sync_q;
   logic              lock_s;
   logic              pll_reset_q, sys_reset_n_q, fault_q;

   assign lock_s = sync_q[1];

   // NOTE: every variable gets a default before the case so no path can leave
   // one unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q + 1'b1;
      retry_d = retry_q;
      loss_d  = loss_q;
      unique case (state_q)
         RESET_PLL: begin
            if (timer_q == RST_LAST) begin
               state_d = WAIT_LOCK;
               timer_d = '0;
            end
         end
         WAIT_LOCK: begin
            // Lock arriving on the timeout cycle takes priority over the retry.
            if (lock_s) begin
               state_d = STABLE;
               timer_d = '0;
            end else if (timer_q == TIMEOUT_LAST) begin
               timer_d = '0;
               if (retry_q == RETRY_LIMIT) begin
                  state_d = FAULT;
               end else begin
                  retry_d = retry_q + 1'b1;
                  state_d = RESET_PLL;
               end
            end
         end
         STABLE: begin
            if (!lock_s) begin
               state_d = WAIT_LOCK;
               timer_d = '0;
            end else if (timer_q == STABLE_LAST) begin
               state_d = RUN;
               timer_d = '0;
               retry_d = '0;
            end
         end
         RUN: begin
            timer_d = '0;
            if (!lock_s) begin
               state_d = RESET_PLL;
               if (loss_q != '1) loss_d = loss_q + 1'b1;
            end
         end
         FAULT: begin
            timer_d = '0;
            if (clear_fault) begin
               state_d = RESET_PLL;
               retry_d = '0;
            end
         end
         default: begin
            state_d = RESET_PLL;
            timer_d = '0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its pre-edge inputs regardless of statement order.
   always_ff @(posedge clk_in1 or negedge reset_n) begin
      if (!reset_n) begin
         sync_q        <= 2'b00;
         state_q       <= RESET_PLL;
         timer_q       <= '0;
         retry_q       <= '0;
         loss_q        <= '0;
         pll_reset_q   <= 1'b1;
         sys_reset_n_q <= 1'b0;
         fault_q       <= 1'b0;
      end else begin
         sync_q        <= {sync_q[0], locked};
         state_q       <= state_d;
         timer_q       <= timer_d;
         retry_q       <= retry_d;
         loss_q        <= loss_d;
         // Outputs are decoded from the next state so they switch with it.
         pll_reset_q   <= (state_d == RESET_PLL) || (state_d == FAULT);
         sys_reset_n_q <= (state_d == RUN);
         fault_q       <= (state_d == FAULT);
      end
   end

   assign pll_reset   = pll_reset_q;
   assign sys_reset_n = sys_reset_n_q;
   assign ready       = sys_reset_n_q;
   assign fault       = fault_q;
   assign state       = state_q;
   assign retry_cnt   = retry_q;
   assign loss_cnt    = loss_q;

endmodule
